dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single-port data memory (MEM_WORDS x 32) between the CPU data port (port 0) and an auxiliary loader/DMA/result-dump master (port 1). It provides round-robin arbitration with anti-starvation aging, address/alignment checking and a fixed 1-cycle read-return path. It sits between cpu_top's d_mem_* port and the data RAM.

Parameters:
MEM_WORDS, 1024, data memory depth in 32-bit words
WORD_AW, 10, word-address width; must equal clog2(MEM_WORDS)
MAX_WAIT, 8, consecutive denied cycles after which a requester becomes urgent (range 1..255)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
p0_req / p1_req  in  1  access request
p0_lock / p1_lock  in  1  hold ownership across accesses (used only with DMEM_ARB_LOCK_EN)
p0_addr / p1_addr  in  32  byte address
p0_wdata / p1_wdata  in  32  write data
p0_wen / p1_wen  in  4  byte write enables; 4'b0000 means read
p0_gnt / p1_gnt  out  1  access accepted this cycle (combinational)
p0_rvalid / p1_rvalid  out  1  read data valid (registered)
p0_rdata / p1_rdata  out  32  read data (registered)
p0_err / p1_err  out  1  one-cycle pulse flagging a bad address on the previous accepted access
mem_en  out  1  memory access strobe
mem_addr  out  WORD_AW  word address = addr[WORD_AW+1:2]
mem_wdata  out  32  write data to memory
mem_wen  out  4  byte write enables to memory
mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_wen==0
owner  out  1  last granted port
locked  out  1  a lock state is active

Behaviour:
- Transfer occurs when pX_req && pX_gnt. At most one gnt is high per cycle. gnt depends only on req, lock, state and counters, never on other outputs.
- mem_* are driven combinationally from the granted port. With no grant: mem_en=0 and mem_wen=0.
- Bad address: addr[1:0]!=0 or addr>=4*MEM_WORDS. The access is still granted, but mem_en=0 and mem_wen=0. Next cycle the port gets pX_err=1; if the access was a read, it also gets pX_rvalid=1 with pX_rdata=0.
- Read (wen==0), good address: pX_rvalid=1 and pX_rdata=mem_rdata exactly 1 cycle after acceptance. Writes produce no rvalid. Back-to-back reads return in order, one per cycle.
- Arbitration in IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: an urgent port wins; if both are urgent, port 0 wins. Otherwise the port != rr_last wins.
  - rr_last is updated on every grant. owner mirrors rr_last.
- Aging: wait_cntX increments, saturating at MAX_WAIT, when reqX && !gntX. It clears on gntX or !reqX. Port X is urgent when wait_cntX==MAX_WAIT.
- FSM states: IDLE, LOCK0, LOCK1. Without DMEM_ARB_LOCK_EN the FSM stays in IDLE.
- Reset (sync, rst=1):
  - State IDLE, rr_last=1 (port 0 wins the first contention), counters 0.
  - rvalid=0, rdata=0, err=0, owner=1, locked=0.
  - gnt and mem_en are forced to 0 while rst=1.
  - A read accepted in the cycle before reset produces no rvalid.

Optional Feature:
DMEM_ARB_LOCK_EN.
- Defined:
  - Entering lock: a grant to port X with pX_lock=1 moves the FSM to LOCKX and sets locked=1.
  - In LOCKX only port X may be granted; idle cycles with lock held are allowed.
  - Exit to IDLE on any of:
    (a) an accepted access by X with pX_lock=0;
    (b) pX_req=0 and pX_lock=0;
    (c) the other port becomes urgent. In that cycle the other port is granted, X is denied, and the FSM enters IDLE with rr_last set to the other port.
- Undefined: lock inputs are ignored, FSM stays IDLE, and locked is tied to 0.

Test Plan:
1. Single read: p0 reads 0x200 with mem_rdata=0x5 -> p0_gnt=1 the same cycle, mem_addr=0x080, mem_en=1; next cycle p0_rvalid=1, p0_rdata=0x5.
2. Contention: p0 and p1 both write continuously (wen=4'b1111) after reset -> grant sequence 0,1,0,1,...; mem_wdata follows the granted port every cycle.
3. Bad address: p1 writes 0x1000 -> gnt=1, mem_en=0, p1_err pulses the next cycle. p0 reads 0x202 -> p0_rvalid=1, p0_rdata=0, p0_err=1.
4. Lock (LOCK_EN, MAX_WAIT=8): p0 runs a 20-cycle locked burst while p1 requests -> p1 is denied 8 cycles, granted in the 9th; locked falls and the next contention grants p0.
5. Reset mid-read: rst=1 the cycle after p0 read acceptance -> no p0_rvalid, all outputs 0 (owner=1); after release, simultaneous requests grant p0 first.
6. No LOCK_EN: p0_lock=1 held high with both ports requesting -> strict alternation continues and locked stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares the single-port data RAM between the CPU data port (p0)
// and an auxiliary loader/DMA master (p1). Optional ownership locking: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter int WORD_AW   = 10,
    parameter int MAX_WAIT  = 8
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               p0_req,
    input  logic               p0_lock,
    input  logic [31:0]        p0_addr,
    input  logic [31:0]        p0_wdata,
    input  logic [3:0]         p0_wen,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,
    output logic               p0_err,

    input  logic               p1_req,
    input  logic               p1_lock,
    input  logic [31:0]        p1_addr,
    input  logic [31:0]        p1_wdata,
    input  logic [3:0]         p1_wen,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,
    output logic               p1_err,

    output logic               mem_en,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wen,
    input  logic [31:0]        mem_rdata,

    output logic               owner,
    output logic               locked
);

`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [7:0]  MAX_W      = 8'(MAX_WAIT);
    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) * 34'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK0,
        ST_LOCK1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr_last;
    logic [7:0]  r_wait0;
    logic [7:0]  r_wait1;

    logic        r_rv0;
    logic        r_rgood0;
    logic        r_err0;
    logic        r_rv1;
    logic        r_rgood1;
    logic        r_err1;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_urg0;
    logic        w_urg1;
    logic        w_lock0;
    logic        w_lock1;
    logic        w_bad0;
    logic        w_bad1;
    logic        w_bad_sel;
    logic        w_any_gnt;

    assign w_urg0  = (r_wait0 == MAX_W);
    assign w_urg1  = (r_wait1 == MAX_W);
    assign w_lock0 = LOCK_EN && p0_lock;
    assign w_lock1 = LOCK_EN && p1_lock;

    assign w_bad0 = (p0_addr[1:0] != 2'b00) || ({2'b00, p0_addr} >= ADDR_LIMIT);
    assign w_bad1 = (p1_addr[1:0] != 2'b00) || ({2'b00, p1_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A lock holder is pre-empted only when the other port has aged to urgent.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOCK0: begin
                if (w_gnt1) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gnt0 && !w_lock0) begin
                    w_state_nxt = ST_IDLE;
                end else if (!p0_req && !w_lock0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK1: begin
                if (w_gnt0) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gnt1 && !w_lock1) begin
                    w_state_nxt = ST_IDLE;
                end else if (!p1_req && !w_lock1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (w_gnt0 && w_lock0) begin
                    w_state_nxt = ST_LOCK0;
                end else if (w_gnt1 && w_lock1) begin
                    w_state_nxt = ST_LOCK1;
                end
            end
        endcase
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            unique case (r_state)
                ST_LOCK0: begin
                    if (p1_req && w_urg1) begin
                        w_gnt1 = 1'b1;
                    end else if (p0_req) begin
                        w_gnt0 = 1'b1;
                    end
                end
                ST_LOCK1: begin
                    if (p0_req && w_urg0) begin
                        w_gnt0 = 1'b1;
                    end else if (p1_req) begin
                        w_gnt1 = 1'b1;
                    end
                end
                default: begin
                    if (p0_req && !p1_req) begin
                        w_gnt0 = 1'b1;
                    end else if (p1_req && !p0_req) begin
                        w_gnt1 = 1'b1;
                    end else if (p0_req && p1_req) begin
                        if (w_urg0) begin
                            w_gnt0 = 1'b1;
                        end else if (w_urg1) begin
                            w_gnt1 = 1'b1;
                        end else if (r_rr_last) begin
                            w_gnt0 = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    // A granted access to a bad address is swallowed: no strobe reaches the RAM.
    assign w_any_gnt = w_gnt0 || w_gnt1;
    assign w_bad_sel = w_gnt1 ? w_bad1 : w_bad0;
    assign mem_en    = w_any_gnt && !w_bad_sel;
    assign mem_addr  = w_gnt1 ? p1_addr[WORD_AW+1:2] : p0_addr[WORD_AW+1:2];
    assign mem_wdata = w_gnt1 ? p1_wdata : p0_wdata;
    assign mem_wen   = mem_en ? (w_gnt1 ? p1_wen : p0_wen) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_wait0   <= 8'd0;
            r_wait1   <= 8'd0;
        end else begin
            if (w_gnt0) begin
                r_rr_last <= 1'b0;
            end else if (w_gnt1) begin
                r_rr_last <= 1'b1;
            end

            if (!p0_req || w_gnt0) begin
                r_wait0 <= 8'd0;
            end else if (r_wait0 != MAX_W) begin
                r_wait0 <= r_wait0 + 8'd1;
            end

            if (!p1_req || w_gnt1) begin
                r_wait1 <= 8'd0;
            end else if (r_wait1 != MAX_W) begin
                r_wait1 <= r_wait1 + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv0    <= 1'b0;
            r_rgood0 <= 1'b0;
            r_err0   <= 1'b0;
            r_rv1    <= 1'b0;
            r_rgood1 <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_rv0    <= w_gnt0 && (p0_wen == 4'b0000);
            r_rgood0 <= w_gnt0 && (p0_wen == 4'b0000) && !w_bad0;
            r_err0   <= w_gnt0 && w_bad0;
            r_rv1    <= w_gnt1 && (p1_wen == 4'b0000);
            r_rgood1 <= w_gnt1 && (p1_wen == 4'b0000) && !w_bad1;
            r_err1   <= w_gnt1 && w_bad1;
        end
    end

    // Returns are masked while rst is high so a read accepted just before reset never completes.
    assign p0_rvalid = r_rv0 && !rst;
    assign p0_rdata  = (r_rgood0 && !rst) ? mem_rdata : 32'h0;
    assign p0_err    = r_err0 && !rst;
    assign p1_rvalid = r_rv1 && !rst;
    assign p1_rdata  = (r_rgood1 && !rst) ? mem_rdata : 32'h0;
    assign p1_err    = r_err1 && !rst;

    assign owner  = rst ? 1'b1 : r_rr_last;
    assign locked = LOCK_EN && !rst && (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; the lock scenario runs when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_lock;
    logic [31:0] p0_addr, p0_wdata;
    logic [3:0]  p0_wen;
    logic        p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_lock;
    logic [31:0] p1_addr, p1_wdata;
    logic [3:0]  p1_wen;
    logic        p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_rdata;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wen;
    logic [31:0] mem_rdata;
    logic        owner, locked;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MEM_WORDS(1024), .WORD_AW(10), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wen(p0_wen), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wen(p1_wen), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0; p0_wen = 0;
        p1_req = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0; p1_wen = 0;
        mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        p0_req = 1; p1_req = 1;
        tick();
        tick();
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt got %0b%0b want 00", p0_gnt, p1_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_wen !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mem got en=%0b wen=%h want 0/0", mem_en, mem_wen); end
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp got rv=%0b%0b err=%0b%0b want 0", p0_rvalid, p1_rvalid, p0_err, p1_err); end
        checks++; if (owner !== 1'b1 || locked !== 1'b0) begin errors++; $display("[TB] FAIL rst_owner got owner=%0b locked=%0b want 1/0", owner, locked); end
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_addr = 32'h200; p0_wen = 4'b0000;
        #1;
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL read_gnt got %0b%0b want 10", p0_gnt, p1_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 10'h080 || mem_wen !== 4'b0000) begin errors++; $display("[TB] FAIL read_mem got en=%0b addr=%h wen=%h want 1/080/0", mem_en, mem_addr, mem_wen); end
        tick();
        p0_req = 0; mem_rdata = 32'h5;
        #1;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h5) begin errors++; $display("[TB] FAIL read_ret got rv=%0b data=%h want 1/5", p0_rvalid, p0_rdata); end
        checks++; if (p0_err !== 1'b0 || p1_rvalid !== 1'b0 || owner !== 1'b0) begin errors++; $display("[TB] FAIL read_side got err=%0b p1rv=%0b owner=%0b want 0/0/0", p0_err, p1_rvalid, owner); end
        tick();
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL read_once got rv=%0b want 0", p0_rvalid); end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic exp0;
        logic exp_owner;
        do_reset();
        p0_req = 1; p0_wen = 4'hF; p0_wdata = 32'hA0A0_0000; p0_addr = 32'h10;
        p1_req = 1; p1_wen = 4'hF; p1_wdata = 32'hB1B1_1111; p1_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            exp0 = (k % 2 == 0);
            exp_owner = (k == 0) ? 1'b1 : ((k - 1) % 2 == 1);
            #1;
            checks++; if (p0_gnt !== exp0 || p1_gnt !== !exp0) begin errors++; $display("[TB] FAIL cont_gnt cycle %0d got %0b%0b want %0b%0b", k, p0_gnt, p1_gnt, exp0, !exp0); end
            checks++; if (mem_wdata !== (exp0 ? 32'hA0A0_0000 : 32'hB1B1_1111) || mem_en !== 1'b1 || mem_wen !== 4'hF) begin errors++; $display("[TB] FAIL cont_mem cycle %0d got wdata=%h en=%0b wen=%h", k, mem_wdata, mem_en, mem_wen); end
            checks++; if (owner !== exp_owner) begin errors++; $display("[TB] FAIL cont_owner cycle %0d got %0b want %0b", k, owner, exp_owner); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_bad_address();
        p1_req = 1; p1_addr = 32'h1000; p1_wen = 4'hF; p1_wdata = 32'h1234_5678;
        #1;
        checks++; if (p1_gnt !== 1'b1 || mem_en !== 1'b0 || mem_wen !== 4'b0000) begin errors++; $display("[TB] FAIL bad_wr got gnt=%0b en=%0b wen=%h want 1/0/0", p1_gnt, mem_en, mem_wen); end
        tick();
        p1_req = 0;
        #1;
        checks++; if (p1_err !== 1'b1 || p1_rvalid !== 1'b0 || p0_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_wr_err got err=%0b rv=%0b p0err=%0b want 1/0/0", p1_err, p1_rvalid, p0_err); end
        tick();
        checks++; if (p1_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_wr_pulse got err=%0b want 0", p1_err); end
        p0_req = 1; p0_addr = 32'h202; p0_wen = 4'b0000;
        #1;
        checks++; if (p0_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL bad_rd got gnt=%0b en=%0b want 1/0", p0_gnt, mem_en); end
        tick();
        p0_req = 0; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0 || p0_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_rd_ret got rv=%0b data=%h err=%0b want 1/0/1", p0_rvalid, p0_rdata, p0_err); end
        tick();
        p0_req = 1; p0_addr = 32'hFFC;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 10'h3FF) begin errors++; $display("[TB] FAIL top_word got en=%0b addr=%h want 1/3FF", mem_en, mem_addr); end
        tick();
        p0_req = 0; mem_rdata = 32'h1234;
        #1;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1234 || p0_err !== 1'b0) begin errors++; $display("[TB] FAIL top_word_ret got rv=%0b data=%h err=%0b want 1/1234/0", p0_rvalid, p0_rdata, p0_err); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                p0_req = 1; p0_addr = 32'(c * 4); p0_wen = 4'b0000;
            end else begin
                p0_req = 0;
            end
            if (c > 0) mem_rdata = 32'h100 + 32'(c - 1);
            #1;
            if (c < 4) begin
                checks++; if (p0_gnt !== 1'b1 || mem_addr !== 10'(c)) begin errors++; $display("[TB] FAIL b2b_issue %0d got gnt=%0b addr=%h want 1/%h", c, p0_gnt, mem_addr, c); end
            end
            if (c > 0) begin
                checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h100 + 32'(c - 1)) begin errors++; $display("[TB] FAIL b2b_ret %0d got rv=%0b data=%h want 1/%h", c, p0_rvalid, p0_rdata, 32'h100 + 32'(c - 1)); end
            end
            tick();
        end
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end got rv=%0b want 0", p0_rvalid); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        p0_req = 1; p0_addr = 32'h10; p0_wen = 4'b0000;
        tick();
        rst = 1; p1_req = 1; p1_addr = 32'h40; p1_wen = 4'b0000; mem_rdata = 32'h77;
        #1;
        checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstrd_ret got rv=%0b data=%h want 0/0", p0_rvalid, p0_rdata); end
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_gnt got %0b%0b en=%0b want 00/0", p0_gnt, p1_gnt, mem_en); end
        checks++; if (owner !== 1'b1 || locked !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_owner got owner=%0b locked=%0b want 1/0", owner, locked); end
        tick();
        rst = 0;
        #1;
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_first got %0b%0b want 10", p0_gnt, p1_gnt); end
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_stale got rv=%0b want 0", p0_rvalid); end
        tick();
        idle_inputs();
        tick();
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        p0_req = 1; p0_lock = 1; p0_wen = 4'hF; p0_addr = 32'h100;
        p1_req = 1; p1_wen = 4'hF; p1_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k < 8) begin
                checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lock_hold %0d got %0b%0b want 10", k, p0_gnt, p1_gnt); end
                checks++; if (locked !== (k != 0)) begin errors++; $display("[TB] FAIL lock_flag %0d got %0b want %0b", k, locked, k != 0); end
            end else if (k == 8) begin
                checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL lock_preempt got %0b%0b want 01", p0_gnt, p1_gnt); end
            end else begin
                checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_after got %0b%0b locked=%0b want 10/0", p0_gnt, p1_gnt, locked); end
            end
            tick();
        end
        idle_inputs();
        tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_release got %0b want 0", locked); end
    endtask
`else
    task automatic test_no_lock();
        logic exp0;
        do_reset();
        p0_req = 1; p0_lock = 1; p0_wen = 4'hF; p0_wdata = 32'h1;
        p1_req = 1; p1_wen = 4'hF; p1_wdata = 32'h2;
        for (int k = 0; k < 6; k++) begin
            exp0 = (k % 2 == 0);
            #1;
            checks++; if (p0_gnt !== exp0 || p1_gnt !== !exp0 || locked !== 1'b0) begin errors++; $display("[TB] FAIL nolock %0d got %0b%0b locked=%0b want %0b%0b/0", k, p0_gnt, p1_gnt, locked, exp0, !exp0); end
            tick();
        end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        clk = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_bad_address();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`else
        test_no_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
